// File: rtl/iob_fifo_dp_ctrl_pkg.sv
// Shared sizing helpers and control encodings for the iob dual-port FIFO family.
// Kept free of module parameters so sync and future async variants can reuse them.
package iob_fifo_dp_ctrl_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 4;

    // Per-cycle occupancy update chosen from the accepted requests.
    typedef enum logic [1:0] {
        LVL_HOLD = 2'd0,
        LVL_INC  = 2'd1,
        LVL_DEC  = 2'd2
    } lvl_op_e;

    function automatic int fifo_depth(input int addr_w);
        return 1 << addr_w;
    endfunction

    // One extra bit so a completely full FIFO (depth itself) is representable.
    function automatic int level_w(input int addr_w);
        return addr_w + 1;
    endfunction

endpackage

// File: rtl/iob_ram_dp.sv
// True dual-port RAM, one clock, registered outputs. Each output register
// loads only while its port is enabled, so read data holds between accesses.
module iob_ram_dp #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              en_a,
    input  logic              we_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [DATA_W-1:0] din_a,
    output logic [DATA_W-1:0] dout_a,
    input  logic              en_b,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] din_b,
    output logic [DATA_W-1:0] dout_b
);

    logic [DATA_W-1:0] mem [0:(1 << ADDR_W)-1];

    // Read-first on each port; storage and output registers carry no reset.
    always_ff @(posedge clk) begin
        if (en_a) begin
            if (we_a) begin
                mem[addr_a] <= din_a;
            end
            dout_a <= mem[addr_a];
        end
        if (en_b) begin
            if (we_b) begin
                mem[addr_b] <= din_b;
            end
            dout_b <= mem[addr_b];
        end
    end

endmodule

// File: rtl/iob_fifo_dp_ctrl.sv
// Single-clock FIFO built around iob_ram_dp: port A writes at wptr, port B reads at rptr.
// Flags decode the registered level only, so no request input reaches a flag combinationally.
module iob_fifo_dp_ctrl
    import iob_fifo_dp_ctrl_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int ALMOST_FULL = fifo_depth(ADDR_W) - 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              w_en,
    input  logic [DATA_W-1:0] w_data,
    output logic              w_full,
    output logic              w_almost_full,
    input  logic              r_en,
    output logic [DATA_W-1:0] r_data,
    output logic              r_empty,
    output logic [ADDR_W:0]   level,
    output logic              w_overflow,
    output logic              r_underflow
);

    localparam int LVL_W = level_w(ADDR_W);
    localparam int DEPTH = fifo_depth(ADDR_W);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] LVL_AF   = LVL_W'(ALMOST_FULL);
    localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);

    logic [ADDR_W-1:0] wptr;
    logic [ADDR_W-1:0] rptr;
    logic              wacc;
    logic              racc;
    lvl_op_e           lvl_op;
    logic [DATA_W-1:0] ram_dout_a_unused;

    assign w_full        = (level == LVL_FULL);
    assign r_empty       = (level == '0);
    assign w_almost_full = (level >= LVL_AF);

    assign wacc = w_en & ~w_full;
    assign racc = r_en & ~r_empty;

    always_comb begin
        lvl_op = LVL_HOLD;
        if (wacc && !racc) begin
            lvl_op = LVL_INC;
        end else if (racc && !wacc) begin
            lvl_op = LVL_DEC;
        end
    end

    // Pointer, occupancy and error-pulse registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr        <= '0;
            rptr        <= '0;
            level       <= '0;
            w_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (wacc) begin
                wptr <= wptr + 1'b1;
            end
            if (racc) begin
                rptr <= rptr + 1'b1;
            end
            case (lvl_op)
                LVL_INC: level <= level + LVL_ONE;
                LVL_DEC: level <= level - LVL_ONE;
                default: level <= level;
            endcase
            w_overflow  <= w_en & w_full;
            r_underflow <= r_en & r_empty;
        end
    end

    // Storage; the port B output register is the one-cycle read stage.
    iob_ram_dp #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk    (clk),
        .en_a   (wacc),
        .we_a   (wacc),
        .addr_a (wptr),
        .din_a  (w_data),
        .dout_a (ram_dout_a_unused),
        .en_b   (racc),
        .we_b   (1'b0),
        .addr_b (rptr),
        .din_b  ({DATA_W{1'b0}}),
        .dout_b (r_data)
    );

endmodule

// File: tb/tb_iob_fifo_dp_ctrl.sv
// Directed bench for iob_fifo_dp_ctrl with a read-data scoreboard.
module tb_iob_fifo_dp_ctrl;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;
    localparam int AF     = 14;
    localparam int DEPTH  = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              w_en = 1'b0;
    logic [DATA_W-1:0] w_data = '0;
    logic              r_en = 1'b0;
    logic              w_full;
    logic              w_almost_full;
    logic [DATA_W-1:0] r_data;
    logic              r_empty;
    logic [ADDR_W:0]   level;
    logic              w_overflow;
    logic              r_underflow;

    int checks   = 0;
    int failures = 0;

    logic [DATA_W-1:0] mdl[$];
    logic [DATA_W-1:0] exp_q[$];

    iob_fifo_dp_ctrl #(
        .DATA_W      (DATA_W),
        .ADDR_W      (ADDR_W),
        .ALMOST_FULL (AF)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .w_en          (w_en),
        .w_data        (w_data),
        .w_full        (w_full),
        .w_almost_full (w_almost_full),
        .r_en          (r_en),
        .r_data        (r_data),
        .r_empty       (r_empty),
        .level         (level),
        .w_overflow    (w_overflow),
        .r_underflow   (r_underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Pops one expectation per read the DUT accepts and compares a half cycle later.
    initial begin : monitor
        logic acc;
        logic [DATA_W-1:0] e;
        forever begin
            @(posedge clk);
            acc = (r_en === 1'b1) && (r_empty === 1'b0) && (rst === 1'b0);
            if (acc) begin
                @(negedge clk);
                if (exp_q.size() == 0) begin
                    chk("unexpected_read", int'(r_data), -1);
                end else begin
                    e = exp_q.pop_front();
                    chk("r_data", int'(r_data), int'(e));
                end
            end
        end
    end

    // One clock of stimulus; entered and left 1 time unit after a rising edge.
    task automatic cyc(input logic we, input logic [DATA_W-1:0] wd, input logic re);
        logic full_m, empty_m, ovf_m, unf_m;
        int lvl_m;
        full_m  = (mdl.size() == DEPTH);
        empty_m = (mdl.size() == 0);
        ovf_m   = we && full_m;
        unf_m   = re && empty_m;
        w_en    = we;
        w_data  = wd;
        r_en    = re;
        if (re && !empty_m) exp_q.push_back(mdl.pop_front());
        if (we && !full_m) mdl.push_back(wd);
        @(posedge clk);
        #1;
        w_en  = 1'b0;
        r_en  = 1'b0;
        lvl_m = mdl.size();
        chk("level", int'(level), lvl_m);
        chk("w_overflow", int'(w_overflow), int'(ovf_m));
        chk("r_underflow", int'(r_underflow), int'(unf_m));
        chk("r_empty", int'(r_empty), int'(lvl_m == 0));
        chk("w_full", int'(w_full), int'(lvl_m == DEPTH));
        chk("w_almost_full", int'(w_almost_full), int'(lvl_m >= AF));
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "simulation time limit");
    end

    initial begin : stim
        // Power-on reset
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("por_level", int'(level), 0);
        chk("por_r_empty", int'(r_empty), 1);
        chk("por_w_full", int'(w_full), 0);
        rst = 1'b0;
        cyc(1'b0, 8'h00, 1'b0);
        cyc(1'b0, 8'h00, 1'b1);
        chk("idle_underflow", int'(r_underflow), 1);
        cyc(1'b0, 8'h00, 1'b0);

        // Fill, overflow, drain
        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, 8'(32'h20 + i), 1'b0);
            if (i == 13) chk("fill_af_at_14", int'(w_almost_full), 1);
            if (i == 12) chk("fill_af_at_13", int'(w_almost_full), 0);
        end
        chk("fill_full", int'(w_full), 1);
        chk("fill_level", int'(level), 16);
        cyc(1'b1, 8'h99, 1'b0);
        chk("ovf_pulse", int'(w_overflow), 1);
        chk("ovf_level", int'(level), 16);
        for (int i = 0; i < 16; i++) cyc(1'b0, 8'h00, 1'b1);
        chk("drain_empty", int'(r_empty), 1);
        cyc(1'b0, 8'h00, 1'b1);
        cyc(1'b0, 8'h00, 1'b0);
        chk("r_data_hold", int'(r_data), 8'h2F);

        // Pointer wrap
        for (int i = 0; i < 10; i++) cyc(1'b1, 8'(32'h30 + i), 1'b0);
        for (int i = 0; i < 10; i++) cyc(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 16; i++) cyc(1'b1, 8'(32'h40 + i), 1'b0);
        chk("wrap_peak", int'(level), 16);
        for (int i = 0; i < 16; i++) cyc(1'b0, 8'h00, 1'b1);
        chk("wrap_empty", int'(r_empty), 1);

        // Simultaneous requests
        cyc(1'b1, 8'h55, 1'b1);
        chk("sim_empty_level", int'(level), 1);
        for (int i = 0; i < 15; i++) cyc(1'b1, 8'(32'h70 + i), 1'b0);
        cyc(1'b1, 8'h99, 1'b1);
        chk("sim_full_level", int'(level), 15);
        for (int i = 0; i < 10; i++) cyc(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 8; i++) cyc(1'b1, 8'(32'h80 + i), 1'b1);
        chk("sim_mid_level", int'(level), 5);
        for (int i = 0; i < 5; i++) cyc(1'b0, 8'h00, 1'b1);

        // Reset asserted while a write is being presented
        for (int i = 0; i < 4; i++) cyc(1'b1, 8'(32'h90 + i), 1'b0);
        w_en   = 1'b1;
        w_data = 8'h94;
        #2;
        rst = 1'b1;
        #1;
        chk("rst_level", int'(level), 0);
        chk("rst_r_empty", int'(r_empty), 1);
        chk("rst_w_full", int'(w_full), 0);
        mdl.delete();
        exp_q.delete();
        @(posedge clk);
        #1;
        w_en = 1'b0;
        rst  = 1'b0;
        cyc(1'b1, 8'hA5, 1'b0);
        chk("post_rst_mem0", int'(dut.u_ram.mem[0]), 8'hA5);
        cyc(1'b0, 8'h00, 1'b1);
        cyc(1'b0, 8'h00, 1'b0);
        chk("post_rst_r_data", int'(r_data), 8'hA5);

        repeat (3) cyc(1'b0, 8'h00, 1'b0);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
